// File: rtl/pipe_skid_reg_pkg.sv
// Shared types and constants for the pipeline stage register.
// A struct of the entry lives in the module because its width depends on DATA_W.
package pipe_skid_reg_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] instr_t;

    // addi x0, x0, 0 -- the canonical bubble instruction
    localparam instr_t NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY,
        BUSY,
        FULL
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and an
// optional two-entry skid buffer (main = output register, skid = overflow).
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int DATA_W = 3 * XLEN,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  instr_t            in_instr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_wren,
    output logic              out_valid,
    input  logic              out_ready,
    output instr_t            out_instr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_wren
);

    typedef struct packed {
        instr_t            instr;
        logic [DATA_W-1:0] data;
        logic              wren;
    } pipe_entry_t;

    localparam pipe_entry_t RESET_ENTRY = '{instr: NOP_INSTR, data: '0, wren: 1'b0};

    skid_state_e state, state_n;
    pipe_entry_t main_q, main_n;
    pipe_entry_t skid_q, skid_n;
    pipe_entry_t in_entry, bubble;
    logic        in_ready_q, in_ready_n;
    logic        accept, drain;

    assign in_entry  = '{instr: in_instr, data: in_data, wren: in_wren};
    // Bubble keeps the last payload so out_data does not toggle needlessly
    assign bubble    = '{instr: NOP_INSTR, data: main_q.data, wren: 1'b0};

    assign out_valid = (state != EMPTY);
    assign out_instr = main_q.instr;
    assign out_data  = main_q.data;
    assign out_wren  = main_q.wren & out_valid;

    assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign drain     = out_valid & out_ready;

    // Without a skid buffer in_ready blocks accept & !drain in BUSY, so the
    // same transition table serves both builds.
    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = EMPTY;
            main_n  = RESET_ENTRY;
            skid_n  = RESET_ENTRY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_n = BUSY;
                        main_n  = in_entry;
                    end
                end
                BUSY: begin
                    if (accept && drain) begin
                        main_n = in_entry;
                    end else if (accept) begin
                        state_n = FULL;
                        skid_n  = in_entry;
                    end else if (drain) begin
                        state_n = EMPTY;
                        main_n  = bubble;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state_n = BUSY;
                        main_n  = skid_q;
                    end
                end
                default: begin
                    state_n = EMPTY;
                    main_n  = RESET_ENTRY;
                end
            endcase
        end
        in_ready_n = (state_n != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            main_q     <= RESET_ENTRY;
            skid_q     <= RESET_ENTRY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_n;
            main_q     <= main_n;
            skid_q     <= skid_n;
            in_ready_q <= in_ready_n;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: a SKID=1 instance (96-bit payload) and a
// SKID=0 instance (16-bit payload) sharing clock and reset.
module tb_pipe_skid_reg;
    import pipe_skid_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        flush, in_valid, in_wren, out_ready;
    instr_t      in_instr;
    logic [95:0] in_data;
    logic        in_ready, out_valid, out_wren;
    instr_t      out_instr;
    logic [95:0] out_data;

    logic        s0_flush, s0_in_valid, s0_in_wren, s0_out_ready;
    instr_t      s0_in_instr;
    logic [15:0] s0_in_data;
    logic        s0_in_ready, s0_out_valid, s0_out_wren;
    instr_t      s0_out_instr;
    logic [15:0] s0_out_data;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(96), .SKID(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_data(in_data), .in_wren(in_wren),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_data(out_data), .out_wren(out_wren)
    );

    pipe_skid_reg #(.DATA_W(16), .SKID(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(s0_flush),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_instr(s0_in_instr),
        .in_data(s0_in_data), .in_wren(s0_in_wren),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_instr(s0_out_instr),
        .out_data(s0_out_data), .out_wren(s0_out_wren)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input instr_t i, input logic [95:0] d, input logic w);
        in_valid = v;
        in_instr = i;
        in_data  = d;
        in_wren  = w;
    endtask

    task automatic check_out(input string name, input logic ev, input instr_t ei,
                             input logic [95:0] ed, input logic ew, input logic er);
        tests_run++;
        if (out_valid !== ev || out_instr !== ei || out_data !== ed ||
            out_wren !== ew || in_ready !== er) begin
            tests_failed++;
            $display("[TB] FAIL %s: got v=%b i=%h d=%h w=%b rdy=%b, want v=%b i=%h d=%h w=%b rdy=%b",
                     name, out_valid, out_instr, out_data, out_wren, in_ready,
                     ev, ei, ed, ew, er);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        check_out("reset", 1'b0, 32'h13, 96'h0, 1'b0, 1'b1);
        tests_run++;
        if (s0_out_valid !== 1'b0 || s0_out_instr !== 32'h13 || s0_out_data !== 16'h0 ||
            s0_out_wren !== 1'b0 || s0_in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_skid0: got v=%b i=%h d=%h w=%b rdy=%b, want 0 13 0 0 1",
                     s0_out_valid, s0_out_instr, s0_out_data, s0_out_wren, s0_in_ready);
        end
    endtask

    task automatic test_pass_through();
        instr_t i;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i = 32'h0050_0093 + instr_t'(k) * 32'h0010_0000;
            drive(1'b1, i, 96'(k + 1), 1'b1);
            step();
            check_out($sformatf("pass_%0d", k), 1'b1, i, 96'(k + 1), 1'b1, 1'b1);
        end
        drive(1'b0, 32'h0, 96'h0, 1'b0);
        step();
        check_out("pass_drain", 1'b0, 32'h13, 96'h4, 1'b0, 1'b1);
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        drive(1'b1, 32'h00A0_0093, 96'hA, 1'b1);
        step();
        check_out("bp_a", 1'b1, 32'h00A0_0093, 96'hA, 1'b1, 1'b1);
        drive(1'b1, 32'h00B0_0113, 96'hB, 1'b0);
        step();
        check_out("bp_full", 1'b1, 32'h00A0_0093, 96'hA, 1'b1, 1'b0);
        drive(1'b1, 32'h00C0_0193, 96'hC, 1'b1);
        step();
        check_out("bp_hold", 1'b1, 32'h00A0_0093, 96'hA, 1'b1, 1'b0);
        out_ready = 1'b1;
        step();
        check_out("bp_b", 1'b1, 32'h00B0_0113, 96'hB, 1'b0, 1'b1);
        step();
        check_out("bp_c", 1'b1, 32'h00C0_0193, 96'hC, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 96'h0, 1'b0);
        step();
        check_out("bp_empty", 1'b0, 32'h13, 96'hC, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h0010_0093, 96'h11, 1'b1);
        step();
        drive(1'b1, 32'h0020_0093, 96'h22, 1'b1);
        step();
        check_out("fl_full", 1'b1, 32'h0010_0093, 96'h11, 1'b1, 1'b0);
        flush = 1'b1;
        drive(1'b1, 32'h0030_0093, 96'h33, 1'b1);
        step();
        check_out("fl_full_flushed", 1'b0, 32'h13, 96'h0, 1'b0, 1'b1);
        flush = 1'b0;
        drive(1'b1, 32'h0040_0093, 96'h44, 1'b1);
        step();
        check_out("fl_busy", 1'b1, 32'h0040_0093, 96'h44, 1'b1, 1'b1);
        // in_ready is high here, so a missing flush gate would accept this one
        flush = 1'b1;
        drive(1'b1, 32'h0050_0093, 96'h55, 1'b1);
        step();
        check_out("fl_busy_flushed", 1'b0, 32'h13, 96'h0, 1'b0, 1'b1);
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 96'h0, 1'b0);
        repeat (2) step();
        check_out("fl_no_ghost", 1'b0, 32'h13, 96'h0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h0060_0093, 96'h66, 1'b1);
        step();
        drive(1'b1, 32'h0070_0093, 96'h77, 1'b1);
        step();
        drive(1'b0, 32'h0, 96'h0, 1'b0);
        check_out("ar_full", 1'b1, 32'h0060_0093, 96'h66, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("ar_immediate", 1'b0, 32'h13, 96'h0, 1'b0, 1'b1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check_out("ar_after", 1'b0, 32'h13, 96'h0, 1'b0, 1'b1);
    endtask

    task automatic test_skid0();
        s0_out_ready = 1'b0;
        s0_in_valid = 1'b1; s0_in_instr = 32'h0080_0093; s0_in_data = 16'hA5A5; s0_in_wren = 1'b1;
        step();
        s0_in_instr = 32'h0090_0093; s0_in_data = 16'h5A5A; s0_in_wren = 1'b0;
        #1;
        tests_run++;
        if (s0_in_ready !== 1'b0 || s0_out_valid !== 1'b1 || s0_out_instr !== 32'h0080_0093 ||
            s0_out_data !== 16'hA5A5 || s0_out_wren !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL s0_stall: got rdy=%b v=%b i=%h d=%h w=%b, want 0 1 00800093 a5a5 1",
                     s0_in_ready, s0_out_valid, s0_out_instr, s0_out_data, s0_out_wren);
        end
        step();
        tests_run++;
        if (s0_out_instr !== 32'h0080_0093 || s0_out_data !== 16'hA5A5) begin
            tests_failed++;
            $display("[TB] FAIL s0_hold: got i=%h d=%h, want 00800093 a5a5", s0_out_instr, s0_out_data);
        end
        s0_out_ready = 1'b1;
        #1;
        tests_run++;
        if (s0_in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL s0_ready_comb: got %b, want 1", s0_in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            tests_run++;
            if (s0_out_valid !== 1'b1 || s0_out_instr !== 32'h0090_0093 + instr_t'(k) * 32'h0010_0000 ||
                s0_out_data !== 16'h5A5A + 16'(k) || s0_out_wren !== 1'b0 || s0_in_ready !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL s0_stream_%0d: got v=%b i=%h d=%h w=%b rdy=%b",
                         k, s0_out_valid, s0_out_instr, s0_out_data, s0_out_wren, s0_in_ready);
            end
            s0_in_instr = 32'h00A0_0093 + instr_t'(k) * 32'h0010_0000;
            s0_in_data  = 16'h5A5B + 16'(k);
        end
        s0_in_valid = 1'b0;
        step();
        tests_run++;
        if (s0_out_valid !== 1'b0 || s0_out_instr !== 32'h13 || s0_out_wren !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL s0_drain: got v=%b i=%h w=%b, want 0 13 0",
                     s0_out_valid, s0_out_instr, s0_out_wren);
        end
    endtask

    initial begin
        flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 96'h0, 1'b0);
        s0_flush = 1'b0; s0_in_valid = 1'b0; s0_in_instr = 32'h0;
        s0_in_data = 16'h0; s0_in_wren = 1'b0; s0_out_ready = 1'b0;

        test_reset();
        test_pass_through();
        test_back_pressure();
        test_flush();
        test_async_reset();
        test_skid0();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
